// File: rtl/vex_l15_req_arbiter.sv
// Shares the tile's single L1.5 request port between the VexRiscv iBus and dBus.
// Only one request is outstanding at a time. Returns are byte-swapped and routed back to the bus that owns the request.
module vex_l15_req_arbiter #(
  parameter int NC_BIT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ibus_cmd_valid,
  input  logic [31:0] ibus_cmd_pc,
  output logic        ibus_cmd_ready,
  output logic        ibus_rsp_valid,
  output logic [31:0] ibus_rsp_inst,
  input  logic        dbus_cmd_valid,
  input  logic        dbus_cmd_wr,
  input  logic [31:0] dbus_cmd_address,
  input  logic [31:0] dbus_cmd_data,
  input  logic [1:0]  dbus_cmd_size,
  output logic        dbus_cmd_ready,
  output logic        dbus_rsp_valid,
  output logic [31:0] dbus_rsp_data,
  output logic        transducer_l15_val,
  output logic [4:0]  transducer_l15_rqtype,
  output logic [2:0]  transducer_l15_size,
  output logic [39:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic        transducer_l15_nc,
  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_val,
  input  logic [3:0]  l15_transducer_returntype,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  output logic        transducer_l15_req_ack,
  output logic        vex_int,
  output logic        arb_busy
);
  localparam logic [4:0] LOAD_RQ   = 5'b00000;
  localparam logic [4:0] STORE_RQ  = 5'b00001;
  localparam logic [2:0] PCX_SZ_1B = 3'b000;
  localparam logic [2:0] PCX_SZ_2B = 3'b001;
  localparam logic [2:0] PCX_SZ_4B = 3'b010;
  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] INT_RET   = 4'b0111;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  typedef struct packed {
    logic        own_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } req_t;

  state_t      state;
  req_t        req;
  logic        last_d;
  logic        gnt_i, gnt_d, ret_ld, ret_done, fin;
  logic [31:0] ret_word;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Round-robin: on a tie the bus not granted last time wins.
  always_comb begin
    gnt_d = (state == IDLE) && dbus_cmd_valid && (!ibus_cmd_valid || !last_d);
    gnt_i = (state == IDLE) && ibus_cmd_valid && !gnt_d;
  end

  assign ibus_cmd_ready         = gnt_i;
  assign dbus_cmd_ready         = gnt_d;
  assign transducer_l15_req_ack = l15_transducer_val;
  assign arb_busy               = (state != IDLE);

  assign ret_ld   = l15_transducer_val && (l15_transducer_returntype == LOAD_RET);
  assign ret_done = ret_ld || (l15_transducer_val && (l15_transducer_returntype == ST_ACK));
  assign fin      = ret_done && ((state == WAIT) || (state == ISSUE && l15_transducer_ack));

  always_comb begin
    case (req.addr[3:2])
      2'd0:    ret_word = l15_transducer_data_0[63:32];
      2'd1:    ret_word = l15_transducer_data_0[31:0];
      2'd2:    ret_word = l15_transducer_data_1[63:32];
      default: ret_word = l15_transducer_data_1[31:0];
    endcase
  end

  always_comb begin
    transducer_l15_val     = 1'b0;
    transducer_l15_rqtype  = LOAD_RQ;
    transducer_l15_size    = PCX_SZ_1B;
    transducer_l15_address = '0;
    transducer_l15_data    = '0;
    transducer_l15_nc      = 1'b0;
    if (state == ISSUE) begin
      transducer_l15_val     = 1'b1;
      transducer_l15_rqtype  = req.wr ? STORE_RQ : LOAD_RQ;
      case (req.size)
        2'd0:    transducer_l15_size = PCX_SZ_1B;
        2'd1:    transducer_l15_size = PCX_SZ_2B;
        default: transducer_l15_size = PCX_SZ_4B;
      endcase
      transducer_l15_address = {{8{req.addr[31]}}, req.addr};
      transducer_l15_data    = req.wr ? {bswap(req.data), bswap(req.data)} : 64'd0;
      transducer_l15_nc      = req.addr[NC_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req            <= '0;
      last_d         <= 1'b0;
      ibus_rsp_valid <= 1'b0;
      ibus_rsp_inst  <= '0;
      dbus_rsp_valid <= 1'b0;
      dbus_rsp_data  <= '0;
      vex_int        <= 1'b0;
    end else begin
      ibus_rsp_valid <= 1'b0;
      dbus_rsp_valid <= 1'b0;
      vex_int <= l15_transducer_val && (l15_transducer_returntype == INT_RET) &&
                 (l15_transducer_data_0[17:16] == 2'b01);
      case (state)
        IDLE: if (gnt_i || gnt_d) begin
          req.own_d <= gnt_d;
          req.wr    <= gnt_d && dbus_cmd_wr;
          req.addr  <= gnt_d ? dbus_cmd_address : ibus_cmd_pc;
          req.data  <= gnt_d ? dbus_cmd_data : 32'd0;
          req.size  <= gnt_d ? dbus_cmd_size : 2'd2;
          last_d    <= gnt_d;
          state     <= ISSUE;
        end
        ISSUE: if (l15_transducer_ack) state <= fin ? IDLE : WAIT;
        WAIT:  if (fin) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fin && ret_ld) begin
        if (req.own_d) begin
          dbus_rsp_valid <= 1'b1;
          dbus_rsp_data  <= bswap(ret_word);
        end else begin
          ibus_rsp_valid <= 1'b1;
          ibus_rsp_inst  <= bswap(ret_word);
        end
      end
    end
  end
endmodule

// File: tb/tb_vex_l15_req_arbiter.sv
// Bench for vex_l15_req_arbiter: directed scenarios plus random traffic checked every cycle
// against a transaction-level model of the one-outstanding-request arbiter.
module tb_vex_l15_req_arbiter;
  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;
  localparam logic [3:0] INT_RET  = 4'b0111;

  typedef struct {
    logic        rst, iv, dv, wr, ack, rval;
    logic [31:0] pc, addr, data;
    logic [1:0]  size;
    logic [3:0]  rt;
    logic [63:0] d0, d1;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst, ibus_cmd_valid, dbus_cmd_valid, dbus_cmd_wr;
  logic [31:0] ibus_cmd_pc, dbus_cmd_address, dbus_cmd_data;
  logic [1:0]  dbus_cmd_size;
  logic        l15_transducer_ack, l15_transducer_val;
  logic [3:0]  l15_transducer_returntype;
  logic [63:0] l15_transducer_data_0, l15_transducer_data_1;
  logic        ibus_cmd_ready, ibus_rsp_valid, dbus_cmd_ready, dbus_rsp_valid;
  logic [31:0] ibus_rsp_inst, dbus_rsp_data;
  logic        transducer_l15_val, transducer_l15_nc, transducer_l15_req_ack, vex_int, arb_busy;
  logic [4:0]  transducer_l15_rqtype;
  logic [2:0]  transducer_l15_size;
  logic [39:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;

  vex_l15_req_arbiter dut (
    .clk(clk), .rst(rst),
    .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_pc(ibus_cmd_pc), .ibus_cmd_ready(ibus_cmd_ready),
    .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_inst(ibus_rsp_inst),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_wr(dbus_cmd_wr), .dbus_cmd_address(dbus_cmd_address),
    .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_size(dbus_cmd_size), .dbus_cmd_ready(dbus_cmd_ready),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_data(dbus_rsp_data),
    .transducer_l15_val(transducer_l15_val), .transducer_l15_rqtype(transducer_l15_rqtype),
    .transducer_l15_size(transducer_l15_size), .transducer_l15_address(transducer_l15_address),
    .transducer_l15_data(transducer_l15_data), .transducer_l15_nc(transducer_l15_nc),
    .l15_transducer_ack(l15_transducer_ack), .l15_transducer_val(l15_transducer_val),
    .l15_transducer_returntype(l15_transducer_returntype),
    .l15_transducer_data_0(l15_transducer_data_0), .l15_transducer_data_1(l15_transducer_data_1),
    .transducer_l15_req_ack(transducer_l15_req_ack), .vex_int(vex_int), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: phase 0 = no request, 1 = request presented awaiting ack, 2 = awaiting return.
  bit          m_known = 0;
  int          m_ph = 0;
  bit          m_last_d = 0;
  bit          m_own_d, m_wr;
  logic [31:0] m_addr, m_data;
  logic [1:0]  m_size;
  bit          m_iv = 0, m_dv = 0, m_int = 0;
  logic [31:0] m_inst = '0, m_ddata = '0;

  // Most recent DUT observation, for the directed literal checks.
  logic        o_ir, o_dr, o_val, o_nc, o_irv, o_drv, o_int, o_busy;
  logic [4:0]  o_rq;
  logic [2:0]  o_sz;
  logic [39:0] o_addr;
  logic [63:0] o_data;
  logic [31:0] o_inst, o_ddata;

  function automatic logic [31:0] swap32(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(3-k) +: 8];
    return r;
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s.rst = 0; s.iv = 0; s.dv = 0; s.wr = 0; s.ack = 0; s.rval = 0;
    s.pc = '0; s.addr = '0; s.data = '0; s.size = '0; s.rt = '0; s.d0 = '0; s.d1 = '0;
    return s;
  endfunction

  task automatic cycle(input stim_t s);
    bit g_i, g_d, iss, done, fin;
    logic [2:0] e_sz;
    logic [31:0] w;
    @(negedge clk);
    rst = s.rst; ibus_cmd_valid = s.iv; ibus_cmd_pc = s.pc;
    dbus_cmd_valid = s.dv; dbus_cmd_wr = s.wr; dbus_cmd_address = s.addr;
    dbus_cmd_data = s.data; dbus_cmd_size = s.size;
    l15_transducer_ack = s.ack; l15_transducer_val = s.rval; l15_transducer_returntype = s.rt;
    l15_transducer_data_0 = s.d0; l15_transducer_data_1 = s.d1;
    #1;
    g_i = 0; g_d = 0;
    if (m_ph == 0) begin
      if (s.iv && s.dv) begin
        g_d = !m_last_d;
        g_i = m_last_d;
      end else begin
        g_i = s.iv;
        g_d = s.dv;
      end
    end
    o_ir = ibus_cmd_ready; o_dr = dbus_cmd_ready; o_val = transducer_l15_val;
    o_rq = transducer_l15_rqtype; o_sz = transducer_l15_size; o_addr = transducer_l15_address;
    o_data = transducer_l15_data; o_nc = transducer_l15_nc; o_irv = ibus_rsp_valid;
    o_inst = ibus_rsp_inst; o_drv = dbus_rsp_valid; o_ddata = dbus_rsp_data;
    o_int = vex_int; o_busy = arb_busy;
    if (m_known) begin
      iss = (m_ph == 1);
      e_sz = !iss ? 3'd0 : (m_size == 2'd0) ? 3'd0 : (m_size == 2'd1) ? 3'd1 : 3'd2;
      chk("ibus_ready", o_ir, g_i);
      chk("dbus_ready", o_dr, g_d);
      chk("l15_val", o_val, iss);
      chk("l15_rqtype", o_rq, (iss && m_wr) ? 5'd1 : 5'd0);
      chk("l15_size", o_sz, e_sz);
      chk("l15_address", o_addr, iss ? {{8{m_addr[31]}}, m_addr} : 40'd0);
      chk("l15_data", o_data, (iss && m_wr) ? {swap32(m_data), swap32(m_data)} : 64'd0);
      chk("l15_nc", o_nc, iss ? m_addr[31] : 1'b0);
      chk("req_ack", transducer_l15_req_ack, s.rval);
      chk("ibus_rsp_valid", o_irv, m_iv);
      chk("ibus_rsp_inst", o_inst, m_inst);
      chk("dbus_rsp_valid", o_drv, m_dv);
      chk("dbus_rsp_data", o_ddata, m_ddata);
      chk("vex_int", o_int, m_int);
      chk("arb_busy", o_busy, m_ph != 0);
    end
    @(posedge clk);
    if (s.rst) begin
      m_known = 1; m_ph = 0; m_last_d = 0;
      m_iv = 0; m_dv = 0; m_int = 0; m_inst = '0; m_ddata = '0;
    end else begin
      m_int = s.rval && s.rt == INT_RET && s.d0[17:16] == 2'b01;
      m_iv = 0; m_dv = 0;
      done = s.rval && (s.rt == LOAD_RET || s.rt == ST_ACK);
      fin = 0;
      if (m_ph == 0 && (g_i || g_d)) begin
        m_own_d = g_d; m_wr = g_d && s.wr;
        m_addr = g_d ? s.addr : s.pc; m_data = g_d ? s.data : 32'd0;
        m_size = g_d ? s.size : 2'd2;
        m_last_d = g_d; m_ph = 1;
      end else if (m_ph == 1 && s.ack) begin
        if (done) fin = 1; else m_ph = 2;
      end else if (m_ph == 2 && done) fin = 1;
      if (fin) begin
        m_ph = 0;
        if (s.rt == LOAD_RET) begin
          w = (m_addr[3:2] == 0) ? s.d0[63:32] : (m_addr[3:2] == 1) ? s.d0[31:0] :
              (m_addr[3:2] == 2) ? s.d1[63:32] : s.d1[31:0];
          if (m_own_d) begin m_dv = 1; m_ddata = swap32(w); end
          else begin m_iv = 1; m_inst = swap32(w); end
        end
      end
    end
  endtask

  initial begin
    stim_t s;
    logic [3:0] rts [4];
    rts[0] = LOAD_RET; rts[1] = ST_ACK; rts[2] = INT_RET; rts[3] = 4'hF;

    s = idle_s(); s.rst = 1;
    cycle(s); cycle(s);
    cycle(idle_s());
    chk("rst_busy", o_busy, 0); chk("rst_val", o_val, 0); chk("rst_irv", o_irv, 0);
    chk("rst_int", o_int, 0); chk("rst_inst", o_inst, 0); chk("rst_ddata", o_ddata, 0);

    // Single fetch
    s = idle_s(); s.iv = 1; s.pc = 32'h8000_0004; cycle(s);
    chk("fetch_ready", o_ir, 1);
    cycle(idle_s());
    chk("fetch_addr", o_addr, 40'hFF_8000_0004); chk("fetch_nc", o_nc, 1);
    chk("fetch_rq", o_rq, 5'd0); chk("fetch_sz", o_sz, 3'd2);
    s = idle_s(); s.ack = 1; cycle(s);
    s = idle_s(); s.rval = 1; s.rt = LOAD_RET; s.d0 = 64'h1122_3344_5566_7788; cycle(s);
    cycle(idle_s());
    chk("fetch_rsp_valid", o_irv, 1); chk("fetch_inst", o_inst, 32'h8877_6655);
    cycle(idle_s());
    chk("fetch_rsp_pulse", o_irv, 0);

    // Store
    s = idle_s(); s.dv = 1; s.wr = 1; s.addr = 32'h0000_1000; s.data = 32'hAABB_CCDD; s.size = 2;
    cycle(s);
    chk("st_ready", o_dr, 1);
    cycle(idle_s());
    chk("st_data", o_data, 64'hDDCC_BBAA_DDCC_BBAA); chk("st_rq", o_rq, 5'd1);
    chk("st_sz", o_sz, 3'd2); chk("st_nc", o_nc, 0);
    cycle(idle_s());
    chk("st_hold", o_data, 64'hDDCC_BBAA_DDCC_BBAA);
    s = idle_s(); s.ack = 1; cycle(s);
    s = idle_s(); s.rval = 1; s.rt = ST_ACK; cycle(s);
    cycle(idle_s());
    chk("st_no_rsp", o_drv, 0); chk("st_idle", o_busy, 0);

    // Contention from reset
    s = idle_s(); s.rst = 1; cycle(s);
    for (int k = 0; k < 4; k++) begin
      s = idle_s(); s.iv = 1; s.dv = 1; s.pc = 32'(k * 4); s.addr = 32'h100 + 32'(k * 4);
      cycle(s);
      chk("cont_dgrant", o_dr, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("cont_igrant", o_ir, (k % 2 == 0) ? 1'b0 : 1'b1);
      s.ack = 1; cycle(s);
      chk("cont_busy_ready", o_ir | o_dr, 0);
      s.ack = 0; s.rval = 1; s.rt = LOAD_RET; cycle(s);
      chk("cont_wait_ready", o_ir | o_dr, 0);
    end

    // Ack and load return in the same cycle
    s = idle_s(); s.dv = 1; s.addr = 32'h0000_2008; s.size = 2; cycle(s);
    s = idle_s(); s.ack = 1; s.rval = 1; s.rt = LOAD_RET; s.d1 = 64'h0102_0304_0506_0708; cycle(s);
    cycle(idle_s());
    chk("sim_rsp_valid", o_drv, 1); chk("sim_rsp_data", o_ddata, 32'h0403_0201);
    chk("sim_idle", o_busy, 0);

    // Interrupt while waiting
    s = idle_s(); s.iv = 1; s.pc = 32'h0000_000C; cycle(s);
    s = idle_s(); s.ack = 1; cycle(s);
    s = idle_s(); s.rval = 1; s.rt = INT_RET; s.d0 = 64'h0000_0000_0001_0000; cycle(s);
    s = idle_s(); s.rval = 1; s.rt = LOAD_RET; s.d1 = 64'h1111_2222_3333_4444; cycle(s);
    chk("int_pulse", o_int, 1); chk("int_still_wait", o_busy, 1);
    cycle(idle_s());
    chk("int_then_load", o_irv, 1); chk("int_load_inst", o_inst, 32'h4444_3333);
    chk("int_one_cycle", o_int, 0);

    // Reset while waiting
    s = idle_s(); s.dv = 1; s.addr = 32'h0000_3000; s.size = 2; cycle(s);
    s = idle_s(); s.ack = 1; cycle(s);
    s = idle_s(); s.rst = 1; cycle(s);
    s = idle_s(); s.rval = 1; s.rt = LOAD_RET; s.d0 = 64'hFFFF_FFFF_FFFF_FFFF; cycle(s);
    cycle(idle_s());
    chk("rstw_no_rsp", o_drv, 0); chk("rstw_busy", o_busy, 0); chk("rstw_val", o_val, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      s = idle_s();
      s.rst  = ($urandom_range(0, 199) == 0);
      s.iv   = $urandom_range(0, 1) == 1;
      s.pc   = $urandom;
      s.dv   = $urandom_range(0, 1) == 1;
      s.wr   = $urandom_range(0, 1) == 1;
      s.addr = $urandom;
      s.data = $urandom;
      s.size = 2'($urandom_range(0, 3));
      s.ack  = (m_ph == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      s.rval = ($urandom_range(0, 3) == 0);
      s.rt   = rts[$urandom_range(0, 3)];
      s.d0   = {$urandom, $urandom};
      s.d1   = {$urandom, $urandom};
      cycle(s);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
